// File: rtl/fpu_add_scheduler.sv
// Round-robin scheduler sharing one combinational single-precision adder among NUM_REQ
// requesters. Operands and result are registered; valid/ready handshakes on both sides.
// Optional macro FPU_SUB_EN adds a per-requester req_sub input that selects A-B.
module fpu_add_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned M_SIZE     = 23,
  parameter int unsigned E_SIZE     = 8,
  parameter int unsigned TOTAL_SIZE = 32,
  parameter int unsigned ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TOTAL_SIZE-1:0] req_a,
  input  logic [NUM_REQ*TOTAL_SIZE-1:0] req_b,
`ifdef FPU_SUB_EN
  input  logic [NUM_REQ-1:0]            req_sub,
`endif
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [TOTAL_SIZE-1:0]         rsp_sum,
  output logic [ID_W-1:0]               rsp_id,
  input  logic                          rsp_ready,
  output logic                          busy
);

  // Significand plus hidden bit plus guard/round/sticky, and a working exponent with headroom.
  localparam int unsigned SW  = M_SIZE + 4;
  localparam int unsigned EXW = E_SIZE + 2;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [TOTAL_SIZE-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [TOTAL_SIZE-1:0]   rsp_sum_q, rsp_sum_d;
  logic [ID_W-1:0]         rsp_id_q, rsp_id_d;
  logic                    sub_q;
`ifdef FPU_SUB_EN
  logic                    sub_d;
  logic                    gnt_sub;
`endif

  logic [NUM_REQ-1:0]      grant_oh;
  logic [ID_W-1:0]         grant_id;
  logic                    grant_found;
  logic [TOTAL_SIZE-1:0]   gnt_a, gnt_b;
  logic [TOTAL_SIZE-1:0]   adder_sum;

  // Round-robin search: first valid at or above rr_ptr, otherwise lowest valid below it.
  always_comb begin
    grant_oh    = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!grant_found && req_valid[j] && (j >= int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_oh[j] = 1'b1;
        grant_id    = ID_W'(j);
      end
    end
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (!grant_found && req_valid[j]) begin
        grant_found = 1'b1;
        grant_oh[j] = 1'b1;
        grant_id    = ID_W'(j);
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
`ifdef FPU_SUB_EN
    gnt_sub = 1'b0;
`endif
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      if (grant_oh[j]) begin
        gnt_a = req_a[j*TOTAL_SIZE +: TOTAL_SIZE];
        gnt_b = req_b[j*TOTAL_SIZE +: TOTAL_SIZE];
`ifdef FPU_SUB_EN
        gnt_sub = req_sub[j];
`endif
      end
    end
  end

  // Shared adder: align, add/subtract, normalise, round to nearest even; specials bypass.
  logic                    sa, sb, eff_sub, swap, big_s, round_up;
  logic [E_SIZE-1:0]       ea, eb, big_e, sml_e, big_ee, sml_ee, diff;
  logic [M_SIZE-1:0]       ma, mb, big_m, sml_m, res_m;
  logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [SW-1:0]           big_x, sml_x, sml_sh, lost_mask, norm;
  logic [SW:0]             raw;
  logic [EXW-1:0]          r_e, res_e;
  logic [M_SIZE+1:0]       rnd;
  logic [TOTAL_SIZE-1:0]   norm_sum;

  always_comb begin
    sa     = op_a_q[TOTAL_SIZE-1];
    sb     = op_b_q[TOTAL_SIZE-1] ^ sub_q;
    ea     = op_a_q[TOTAL_SIZE-2 -: E_SIZE];
    eb     = op_b_q[TOTAL_SIZE-2 -: E_SIZE];
    ma     = op_a_q[M_SIZE-1:0];
    mb     = op_b_q[M_SIZE-1:0];
    a_nan  = (ea == '1) && (ma != '0);
    b_nan  = (eb == '1) && (mb != '0);
    a_inf  = (ea == '1) && (ma == '0);
    b_inf  = (eb == '1) && (mb == '0);
    a_zero = (ea == '0) && (ma == '0);
    b_zero = (eb == '0) && (mb == '0);

    swap   = op_b_q[TOTAL_SIZE-2:0] > op_a_q[TOTAL_SIZE-2:0];
    big_s  = swap ? sb : sa;
    big_e  = swap ? eb : ea;
    big_m  = swap ? mb : ma;
    sml_e  = swap ? ea : eb;
    sml_m  = swap ? ma : mb;
    big_x  = {(big_e != '0), big_m, 3'b000};
    sml_x  = {(sml_e != '0), sml_m, 3'b000};
    // Subnormals share the minimum normal exponent.
    big_ee = (big_e == '0) ? E_SIZE'(1) : big_e;
    sml_ee = (sml_e == '0) ? E_SIZE'(1) : sml_e;
    diff   = big_ee - sml_ee;

    lost_mask = '0;
    if (32'(diff) >= SW) begin
      sml_sh    = '0;
      sml_sh[0] = |sml_x;
    end else begin
      lost_mask = ~({SW{1'b1}} << diff);
      sml_sh    = sml_x >> diff;
      sml_sh[0] = sml_sh[0] | (|(sml_x & lost_mask));
    end

    eff_sub = sa ^ sb;
    raw = eff_sub ? ({1'b0, big_x} - {1'b0, sml_sh}) : ({1'b0, big_x} + {1'b0, sml_sh});
    r_e = {2'b00, big_ee};

    if (raw[SW]) begin
      norm    = raw[SW:1];
      norm[0] = norm[0] | raw[0];
      r_e     = r_e + EXW'(1);
    end else begin
      norm = raw[SW-1:0];
    end
    // Left-normalise, stopping at the minimum exponent so results can go subnormal.
    for (int i = 0; i < int'(SW); i++) begin
      if (!norm[SW-1] && (r_e > EXW'(1))) begin
        norm = norm << 1;
        r_e  = r_e - EXW'(1);
      end
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[SW-1:3]} + (M_SIZE+2)'(round_up);
    if (rnd[M_SIZE+1]) begin
      res_e = r_e + EXW'(1);
      res_m = rnd[M_SIZE:1];
    end else begin
      res_e = rnd[M_SIZE] ? r_e : '0;
      res_m = rnd[M_SIZE-1:0];
    end

    if (raw == '0) begin
      norm_sum = {sa & sb, {(TOTAL_SIZE-1){1'b0}}};
    end else if (res_e >= {2'b00, {E_SIZE{1'b1}}}) begin
      norm_sum = {big_s, {E_SIZE{1'b1}}, {M_SIZE{1'b0}}};
    end else begin
      norm_sum = {big_s, res_e[E_SIZE-1:0], res_m};
    end

    if (a_nan) begin
      adder_sum = op_a_q;
    end else if (b_nan) begin
      adder_sum = {sb, op_b_q[TOTAL_SIZE-2:0]};
    end else if (a_inf && b_inf && eff_sub) begin
      adder_sum = {1'b0, {E_SIZE{1'b1}}, 1'b1, {(M_SIZE-1){1'b0}}};
    end else if (a_inf) begin
      adder_sum = op_a_q;
    end else if (b_inf) begin
      adder_sum = {sb, op_b_q[TOTAL_SIZE-2:0]};
    end else if (a_zero && b_zero) begin
      adder_sum = {sa & sb, {(TOTAL_SIZE-1){1'b0}}};
    end else if (a_zero) begin
      adder_sum = {sb, op_b_q[TOTAL_SIZE-2:0]};
    end else if (b_zero) begin
      adder_sum = op_a_q;
    end else begin
      adder_sum = norm_sum;
    end
  end

  // Next-state and handshake logic for the IDLE -> CALC -> DONE cycle.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
`ifdef FPU_SUB_EN
    sub_d       = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        rsp_valid_d = 1'b0;
        if (grant_found) begin
          op_a_d   = gnt_a;
          op_b_d   = gnt_b;
          id_d     = grant_id;
`ifdef FPU_SUB_EN
          sub_d    = gnt_sub;
`endif
          rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        rsp_sum_d   = adder_sum;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef FPU_SUB_EN
  // Latched subtract flag, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`else
  assign sub_q = 1'b0;
`endif

  // Grants are only offered in IDLE and never while reset is held.
  assign req_ready = ((state_q == StIdle) && !rst) ? grant_oh : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != StIdle);

endmodule
